// File: rtl/link_supervisor.sv
// Link-level controller: header validation, accept strobe, frame watchdog and
// the IDLE/RUN/FAULT/ESTOP state machine that gates joint enables and reply header.
module link_supervisor #(
  parameter int          JOINTS         = 5,
  parameter int          TIMEOUT_CYCLES = 4800000,
  parameter int          MISS_LIMIT     = 3,
  parameter logic [31:0] HEADER_RX      = 32'h74697277
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [31:0]       header_rx,
  input  logic [JOINTS-1:0] joint_enable_req,
  input  logic              estop_req,
  input  logic              estop_clear,
  output logic              frame_accept,
  output logic [JOINTS-1:0] joint_enable,
  output logic [31:0]       header_tx,
  output logic [1:0]        link_state,
  output logic              link_timeout,
  output logic              error,
  output logic [7:0]        bad_frame_count
);

  localparam int          WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] HDR_DATA = 32'h64617461;
  localparam logic [31:0] HDR_ESTP = 32'h65737470;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2,
    S_ESTOP = 2'd3
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic [3:0]        miss_cnt;
  logic              good;
  logic              bad;
  logic              wd_expire;
  logic              miss_reach;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc_miss(input logic [3:0] v);
    return ({1'b0, v} >= 5'(MISS_LIMIT)) ? v : v + 4'd1;
  endfunction

  assign good       = frame_valid && (header_rx == HEADER_RX);
  assign bad        = frame_valid && (header_rx != HEADER_RX);
  assign wd_expire  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign miss_reach = bad && (({1'b0, miss_cnt} + 5'd1) >= 5'(MISS_LIMIT));

  // Next-state decision; estop dominates, and a good frame beats watchdog expiry.
  always_comb begin
    nxt = state;
    if (estop_req) begin
      nxt = S_ESTOP;
    end else begin
      case (state)
        S_IDLE:  if (good) nxt = S_RUN;
        S_RUN:   if (!good && (wd_expire || miss_reach)) nxt = S_FAULT;
        S_FAULT: if (estop_clear) nxt = S_IDLE;
        S_ESTOP: if (estop_clear) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state           <= S_IDLE;
      wd_cnt          <= '0;
      miss_cnt        <= '0;
      frame_accept    <= 1'b0;
      joint_enable    <= '0;
      header_tx       <= HDR_DATA;
      link_timeout    <= 1'b0;
      error           <= 1'b1;
      bad_frame_count <= '0;
    end else begin
      state        <= nxt;
      frame_accept <= good;
      joint_enable <= joint_enable_req & {JOINTS{nxt == S_RUN}};
      header_tx    <= (nxt == S_ESTOP) ? HDR_ESTP : HDR_DATA;
      link_timeout <= (nxt == S_FAULT);
      error        <= (nxt != S_RUN);

      if (good || state != S_RUN || nxt != S_RUN)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;

      if (good || nxt != state)
        miss_cnt <= '0;
      else if (bad)
        miss_cnt <= sat_inc_miss(miss_cnt);

      if (bad)
        bad_frame_count <= sat_inc8(bad_frame_count);
    end
  end

  assign link_state = state;

endmodule

// File: tb/tb_link_supervisor.sv
// Directed bench for link_supervisor with a shortened watchdog (100 cycles).
module tb_link_supervisor;

  localparam int          JOINTS = 5;
  localparam int          TMO    = 100;
  localparam logic [31:0] GOOD   = 32'h74697277;
  localparam logic [31:0] BAD    = 32'hDEADBEEF;
  localparam logic [31:0] DATA   = 32'h64617461;
  localparam logic [31:0] ESTP   = 32'h65737470;

  logic              sysclk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_valid = 1'b0;
  logic [31:0]       header_rx = '0;
  logic [JOINTS-1:0] joint_enable_req = '0;
  logic              estop_req = 1'b0;
  logic              estop_clear = 1'b0;
  logic              frame_accept;
  logic [JOINTS-1:0] joint_enable;
  logic [31:0]       header_tx;
  logic [1:0]        link_state;
  logic              link_timeout;
  logic              error;
  logic [7:0]        bad_frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  link_supervisor #(
    .JOINTS(JOINTS), .TIMEOUT_CYCLES(TMO), .MISS_LIMIT(3), .HEADER_RX(GOOD)
  ) dut (
    .sysclk(sysclk), .reset(reset), .frame_valid(frame_valid), .header_rx(header_rx),
    .joint_enable_req(joint_enable_req), .estop_req(estop_req), .estop_clear(estop_clear),
    .frame_accept(frame_accept), .joint_enable(joint_enable), .header_tx(header_tx),
    .link_state(link_state), .link_timeout(link_timeout), .error(error),
    .bad_frame_count(bad_frame_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send(input logic [31:0] h);
    frame_valid = 1'b1;
    header_rx   = h;
    tick();
    frame_valid = 1'b0;
    header_rx   = '0;
  endtask

  task automatic pulse_clear();
    estop_clear = 1'b1;
    tick();
    estop_clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(link_state), 32'd0);
    check_eq({tag, "_accept"}, 32'(frame_accept), 32'd0);
    check_eq({tag, "_je"}, 32'(joint_enable), 32'd0);
    check_eq({tag, "_hdr"}, header_tx, DATA);
    check_eq({tag, "_tmo"}, 32'(link_timeout), 32'd0);
    check_eq({tag, "_err"}, 32'(error), 32'd1);
    check_eq({tag, "_bfc"}, 32'(bad_frame_count), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Good frame from IDLE
    joint_enable_req = 5'b10101;
    send(GOOD);
    check_eq("acc_pulse", 32'(frame_accept), 32'd1);
    check_eq("run_state", 32'(link_state), 32'd1);
    check_eq("run_err", 32'(error), 32'd0);
    check_eq("run_je", 32'(joint_enable), 32'h15);
    tick();
    check_eq("acc_one_cycle", 32'(frame_accept), 32'd0);

    // Watchdog: frame sampled at edge e, FAULT visible after edge e+TMO
    send(GOOD);
    repeat (TMO - 1) tick();
    check_eq("wd_before", 32'(link_state), 32'd1);
    tick();
    check_eq("wd_fault", 32'(link_state), 32'd2);
    check_eq("wd_tmo", 32'(link_timeout), 32'd1);
    check_eq("wd_je", 32'(joint_enable), 32'd0);
    check_eq("wd_err", 32'(error), 32'd1);
    pulse_clear();
    check_eq("clr_idle", 32'(link_state), 32'd0);
    check_eq("clr_tmo", 32'(link_timeout), 32'd0);
    send(GOOD);
    check_eq("rerun", 32'(link_state), 32'd1);

    // Three consecutive bad headers
    send(BAD);
    check_eq("bad1_state", 32'(link_state), 32'd1);
    check_eq("bad1_acc", 32'(frame_accept), 32'd0);
    send(BAD);
    check_eq("bad2_state", 32'(link_state), 32'd1);
    send(BAD);
    check_eq("bad3_state", 32'(link_state), 32'd2);
    check_eq("bad3_bfc", 32'(bad_frame_count), 32'd3);
    check_eq("bad3_acc", 32'(frame_accept), 32'd0);
    pulse_clear();
    send(GOOD);
    check_eq("bad_rerun", 32'(link_state), 32'd1);
    send(BAD);
    send(BAD);
    send(GOOD);
    check_eq("bbg_acc", 32'(frame_accept), 32'd1);
    send(BAD);
    check_eq("bbgb_state", 32'(link_state), 32'd1);
    check_eq("bbgb_bfc", 32'(bad_frame_count), 32'd6);

    // Emergency stop
    estop_req = 1'b1;
    tick();
    check_eq("es_hdr", header_tx, ESTP);
    check_eq("es_state", 32'(link_state), 32'd3);
    check_eq("es_je", 32'(joint_enable), 32'd0);
    send(GOOD);
    check_eq("es_acc", 32'(frame_accept), 32'd1);
    check_eq("es_stay_good", 32'(link_state), 32'd3);
    pulse_clear();
    check_eq("es_clr_held", 32'(link_state), 32'd3);
    estop_req = 1'b0;
    tick();
    check_eq("es_released", 32'(link_state), 32'd3);
    pulse_clear();
    check_eq("es_idle", 32'(link_state), 32'd0);
    check_eq("es_idle_hdr", header_tx, DATA);

    // Good frame coincident with watchdog expiry keeps RUN and restarts the count
    send(GOOD);
    repeat (TMO - 1) tick();
    send(GOOD);
    check_eq("coinc_run", 32'(link_state), 32'd1);
    repeat (TMO - 1) tick();
    check_eq("coinc_restart", 32'(link_state), 32'd1);
    tick();
    check_eq("coinc_fault", 32'(link_state), 32'd2);

    // Back-to-back bad frames saturate the counter
    frame_valid = 1'b1;
    header_rx   = BAD;
    repeat (300) tick();
    frame_valid = 1'b0;
    check_eq("bfc_sat", 32'(bad_frame_count), 32'd255);

    // Back-to-back good frames each accepted
    pulse_clear();
    frame_valid = 1'b1;
    header_rx   = GOOD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("b2b_acc%0d", i), 32'(frame_accept), 32'd1);
    end
    frame_valid = 1'b0;
    tick();
    check_eq("b2b_state", 32'(link_state), 32'd1);

    // Reset coincident with a frame, then reset right after a frame
    frame_valid = 1'b1;
    header_rx   = GOOD;
    reset       = 1'b1;
    tick();
    frame_valid = 1'b0;
    reset       = 1'b0;
    check_reset_outputs("rst_coinc");
    send(GOOD);
    check_eq("pre_rst_acc", 32'(frame_accept), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
